// File: rtl/csr_port_sched.sv
// csr_port_sched
// Phase sequencer and port-A scheduler for the three CSR matrix RAMs
// (value, column-index, row-pointer). One owner drives the RAM port-A
// address / write-enable / write-data lines. The port is shared between the
// matrix loader (writes), the sparse multiplier (reads) and a host readback
// path (reads). The run is sequenced IDLE -> LOAD -> COMPUTE -> FINISH.
//
// Ports
//   clk, reset            : single rising-edge clock, synchronous active-high reset
//   start                 : begin a run (honoured in IDLE and FINISH only)
//   phase                 : 0 IDLE, 1 LOAD, 2 COMPUTE, 3 FINISH
//   mul_start             : one-cycle pulse on entry to COMPUTE
//   mu_done               : multiplier finished (COMPUTE -> FINISH)
//   done                  : high while phase is FINISH
//   ld_*                  : loader write requester (req/last/sel/addr/wdata/gnt)
//   mu_*                  : multiplier read requester (req/sel/addr/gnt/rdata/rvalid)
//   hs_*                  : host read requester (req/sel/addr/gnt/rdata/rvalid)
//   addr_val/col/row, we_val/col/row, din : registered RAM port A
//   dout_val/col/row      : RAM port-A read data
//   err                   : one-cycle pulse after an accepted request is dropped
//
// sel encoding: 0 value, 1 column, 2 row, 3 reserved.
// Assumes ADDR_W > 10 and RD_LAT >= 1.

module csr_port_sched #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [1:0]        phase,
    output logic              mul_start,
    input  logic              mu_done,
    output logic              done,

    input  logic              ld_req,
    input  logic              ld_last,
    input  logic [1:0]        ld_sel,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,

    input  logic              mu_req,
    input  logic [1:0]        mu_sel,
    input  logic [ADDR_W-1:0] mu_addr,
    output logic              mu_gnt,
    output logic [DATA_W-1:0] mu_rdata,
    output logic              mu_rvalid,

    input  logic              hs_req,
    input  logic [1:0]        hs_sel,
    input  logic [ADDR_W-1:0] hs_addr,
    output logic              hs_gnt,
    output logic [DATA_W-1:0] hs_rdata,
    output logic              hs_rvalid,

    output logic [ADDR_W-1:0] addr_val,
    output logic [ADDR_W-1:0] addr_col,
    output logic [9:0]        addr_row,
    output logic              we_val,
    output logic              we_col,
    output logic              we_row,
    output logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout_val,
    input  logic [DATA_W-1:0] dout_col,
    input  logic [DATA_W-1:0] dout_row,

    output logic              err
);

    localparam int ROW_W = 10;

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_LOAD    = 2'd1,
        PH_COMPUTE = 2'd2,
        PH_FINISH  = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        SEL_VAL  = 2'd0,
        SEL_COL  = 2'd1,
        SEL_ROW  = 2'd2,
        SEL_RSVD = 2'd3
    } sel_t;

    // Read-return tag: only reads are tagged, so the requester is mu (0) or hs (1).
    typedef struct packed {
        logic valid;
        logic hs;
        sel_t sel;
    } tag_t;

    phase_t              phase_q;
    logic                mu_prio;      // 1: multiplier wins the next COMPUTE tie
    logic                acc;
    logic                acc_wr;
    logic                acc_drop;
    sel_t                acc_sel;
    logic [ADDR_W-1:0]   acc_addr;
    tag_t                tag_in;
    tag_t                tag_q [RD_LAT+1];
    tag_t                tag_out;
    logic [DATA_W-1:0]   ret_data;

    assign phase = phase_q;

    // ------------------------------------------------------------------
    // Grant logic: combinational from current requests, phase and priority.
    // Held low during reset so nothing is accepted on the reset edge.
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        ld_gnt = 1'b0;
        mu_gnt = 1'b0;
        hs_gnt = 1'b0;
        if (!reset) begin
            case (phase_q)
                PH_LOAD:    ld_gnt = ld_req;
                PH_COMPUTE: begin
                    if (mu_req && (!hs_req || mu_prio)) mu_gnt = 1'b1;
                    else if (hs_req)                    hs_gnt = 1'b1;
                end
                default:    hs_gnt = hs_req;   // IDLE and FINISH: host only
            endcase
        end
    end

    // Mux the granted requester onto a single accepted-request view.
    always_comb begin
        acc_sel  = sel_t'(ld_sel);
        acc_addr = ld_addr;
        acc_wr   = 1'b0;
        if (ld_gnt) begin
            acc_wr = 1'b1;
        end else if (mu_gnt) begin
            acc_sel  = sel_t'(mu_sel);
            acc_addr = mu_addr;
        end else if (hs_gnt) begin
            acc_sel  = sel_t'(hs_sel);
            acc_addr = hs_addr;
        end
    end

    assign acc = ld_gnt | mu_gnt | hs_gnt;

    // Accepted but not issued: reserved select, or a row address beyond the
    // 10-bit row RAM.
    assign acc_drop = acc && ((acc_sel == SEL_RSVD) ||
                              ((acc_sel == SEL_ROW) && (|acc_addr[ADDR_W-1:ROW_W])));

    assign tag_in = '{valid: acc && !acc_drop && !acc_wr, hs: hs_gnt, sel: acc_sel};

    // ------------------------------------------------------------------
    // Phase FSM with registered mul_start / done, plus round-robin pointer.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q   <= PH_IDLE;
            mul_start <= 1'b0;
            done      <= 1'b0;
            mu_prio   <= 1'b1;
        end else begin
            mul_start <= 1'b0;
            case (phase_q)
                PH_IDLE: begin
                    if (start) phase_q <= PH_LOAD;
                end
                PH_LOAD: begin
                    if (ld_gnt && ld_last) begin
                        phase_q   <= PH_COMPUTE;
                        mul_start <= 1'b1;
                    end
                end
                PH_COMPUTE: begin
                    if (mu_done) begin
                        phase_q <= PH_FINISH;
                        done    <= 1'b1;
                    end
                end
                PH_FINISH: begin
                    if (start) begin
                        phase_q <= PH_LOAD;
                        done    <= 1'b0;
                    end
                end
            endcase

            // Priority passes to the other reader after every reader grant.
            if (mu_gnt)      mu_prio <= 1'b0;
            else if (hs_gnt) mu_prio <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Issue: register the accepted request onto RAM port A. Only the
    // selected RAM's address moves; the others hold.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_val <= '0;
            addr_col <= '0;
            addr_row <= '0;
            we_val   <= 1'b0;
            we_col   <= 1'b0;
            we_row   <= 1'b0;
            din      <= '0;
            err      <= 1'b0;
        end else begin
            we_val <= 1'b0;
            we_col <= 1'b0;
            we_row <= 1'b0;
            err    <= acc_drop;
            if (acc && !acc_drop) begin
                case (acc_sel)
                    SEL_VAL: begin
                        addr_val <= acc_addr;
                        we_val   <= acc_wr;
                    end
                    SEL_COL: begin
                        addr_col <= acc_addr;
                        we_col   <= acc_wr;
                    end
                    default: begin
                        addr_row <= acc_addr[ROW_W-1:0];
                        we_row   <= acc_wr;
                    end
                endcase
                if (acc_wr) din <= ld_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return: tag stage 0 is loaded on the accept edge; the last stage
    // lines up with RAM data, which is captured into the requester's rdata.
    // ------------------------------------------------------------------
    assign tag_out = tag_q[RD_LAT];

    always_comb begin
        case (tag_out.sel)
            SEL_VAL: ret_data = dout_val;
            SEL_COL: ret_data = dout_col;
            default: ret_data = dout_row;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Flushing the tags guarantees no rvalid from reads in flight.
            for (int i = 0; i <= RD_LAT; i++) tag_q[i] <= '0;
            mu_rvalid <= 1'b0;
            hs_rvalid <= 1'b0;
            mu_rdata  <= '0;
            hs_rdata  <= '0;
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i <= RD_LAT; i++) tag_q[i] <= tag_q[i-1];
            mu_rvalid <= tag_out.valid && !tag_out.hs;
            hs_rvalid <= tag_out.valid &&  tag_out.hs;
            if (tag_out.valid) begin
                if (tag_out.hs) hs_rdata <= ret_data;
                else            mu_rdata <= ret_data;
            end
        end
    end

endmodule

// File: tb/tb_csr_port_sched.sv
// Directed self-checking bench for csr_port_sched with a two-stage-latency
// RAM model driving dout_*. Covers reset, load, round-robin reads, drops,
// phase rules, mid-run reset and FINISH read return.

module tb_csr_port_sched;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        phase;
    logic              mul_start;
    logic              mu_done;
    logic              done;
    logic              ld_req, ld_last, ld_gnt;
    logic [1:0]        ld_sel;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              mu_req, mu_gnt, mu_rvalid;
    logic [1:0]        mu_sel;
    logic [ADDR_W-1:0] mu_addr;
    logic [DATA_W-1:0] mu_rdata;
    logic              hs_req, hs_gnt, hs_rvalid;
    logic [1:0]        hs_sel;
    logic [ADDR_W-1:0] hs_addr;
    logic [DATA_W-1:0] hs_rdata;
    logic [ADDR_W-1:0] addr_val, addr_col;
    logic [9:0]        addr_row;
    logic              we_val, we_col, we_row;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout_val, dout_col, dout_row;
    logic              err;

    int n_checks = 0;
    int n_errors = 0;

    csr_port_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .phase(phase),
        .mul_start(mul_start), .mu_done(mu_done), .done(done),
        .ld_req(ld_req), .ld_last(ld_last), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_wdata(ld_wdata), .ld_gnt(ld_gnt),
        .mu_req(mu_req), .mu_sel(mu_sel), .mu_addr(mu_addr), .mu_gnt(mu_gnt),
        .mu_rdata(mu_rdata), .mu_rvalid(mu_rvalid),
        .hs_req(hs_req), .hs_sel(hs_sel), .hs_addr(hs_addr), .hs_gnt(hs_gnt),
        .hs_rdata(hs_rdata), .hs_rvalid(hs_rvalid),
        .addr_val(addr_val), .addr_col(addr_col), .addr_row(addr_row),
        .we_val(we_val), .we_col(we_col), .we_row(we_row), .din(din),
        .dout_val(dout_val), .dout_col(dout_col), .dout_row(dout_row),
        .err(err)
    );

    always #5 clk = ~clk;

    // RAM model: address seen at edge E+1 is read, data presented after edge
    // E+2, so the DUT samples it at edge E+3 (RD_LAT = 2). Read-first on write.
    logic [31:0] mem_val [16384];
    logic [31:0] mem_col [16384];
    logic [31:0] mem_row [1024];

    initial begin
        logic [31:0] val_s1, col_s1, row_s1;
        logic [31:0] nv, nc, nr;
        for (int i = 0; i < 16384; i++) begin
            mem_val[i] = 32'hEE00_0000 | 32'(i);
            mem_col[i] = 32'hC000_0000 | 32'(i);
        end
        for (int i = 0; i < 1024; i++) mem_row[i] = 32'hD000_0000 | 32'(i);
        val_s1 = '0; col_s1 = '0; row_s1 = '0;
        dout_val = '0; dout_col = '0; dout_row = '0;
        forever begin
            @(posedge clk);
            nv = val_s1; nc = col_s1; nr = row_s1;
            val_s1 = mem_val[addr_val];
            col_s1 = mem_col[addr_col];
            row_s1 = mem_row[addr_row];
            if (we_val) mem_val[addr_val] = din;
            if (we_col) mem_col[addr_col] = din;
            if (we_row) mem_row[addr_row] = din;
            #1;
            dout_val = nv; dout_col = nc; dout_row = nr;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_phase"},     32'(phase), 0);
        check({tag, "_ld_gnt"},    32'(ld_gnt), 0);
        check({tag, "_mu_gnt"},    32'(mu_gnt), 0);
        check({tag, "_hs_gnt"},    32'(hs_gnt), 0);
        check({tag, "_mul_start"}, 32'(mul_start), 0);
        check({tag, "_done"},      32'(done), 0);
        check({tag, "_we"},        32'({we_val, we_col, we_row}), 0);
        check({tag, "_din"},       din, 0);
        check({tag, "_addr_val"},  32'(addr_val), 0);
        check({tag, "_addr_col"},  32'(addr_col), 0);
        check({tag, "_addr_row"},  32'(addr_row), 0);
        check({tag, "_err"},       32'(err), 0);
        check({tag, "_rvalid"},    32'({mu_rvalid, hs_rvalid}), 0);
        check({tag, "_mu_rdata"},  mu_rdata, 0);
        check({tag, "_hs_rdata"},  hs_rdata, 0);
    endtask

    initial begin
        // ---------------- reset (host request pending, must not be granted)
        reset = 1'b1; start = 1'b0; mu_done = 1'b0;
        ld_req = 1'b0; ld_last = 1'b0; ld_sel = 2'd0; ld_addr = '0; ld_wdata = '0;
        mu_req = 1'b0; mu_sel = 2'd0; mu_addr = '0;
        hs_req = 1'b1; hs_sel = 2'd0; hs_addr = '0;
        tick(); tick();
        check_all_zero("rst");
        hs_req = 1'b0; reset = 1'b0;
        tick();
        check("idle_phase", 32'(phase), 0);

        // ---------------- LOAD: 4 value writes, host locked out
        start = 1'b1; tick(); start = 1'b0;
        check("load_phase", 32'(phase), 1);
        hs_req = 1'b1; hs_sel = 2'd0; hs_addr = '0;
        for (int i = 0; i < 4; i++) begin
            ld_req = 1'b1; ld_sel = 2'd0; ld_addr = ADDR_W'(i);
            ld_wdata = 32'hA0 + 32'(i); ld_last = (i == 3);
            #1;
            check("ld_gnt", 32'(ld_gnt), 1);
            check("hs_gnt_in_load", 32'(hs_gnt), 0);
            tick();
            check("ld_we_val", 32'(we_val), 1);
            check("ld_we_other", 32'({we_col, we_row}), 0);
            check("ld_addr_val", 32'(addr_val), 32'(i));
            check("ld_din", din, 32'hA0 + 32'(i));
            check("ld_phase", 32'(phase), (i == 3) ? 32'd2 : 32'd1);
            check("ld_mul_start", 32'(mul_start), 32'(i == 3));
        end
        ld_req = 1'b0; ld_last = 1'b0; hs_req = 1'b0;
        tick();
        check("mul_start_low", 32'(mul_start), 0);
        check("we_val_low", 32'(we_val), 0);
        check("compute_phase", 32'(phase), 2);

        // ---------------- COMPUTE: both readers held 4 cycles -> mu,hs,mu,hs
        for (int t = 0; t < 8; t++) begin
            if (t < 4) begin
                mu_req = 1'b1; mu_sel = 2'd0; mu_addr = ADDR_W'(t);
                hs_req = 1'b1; hs_sel = 2'd1; hs_addr = ADDR_W'(t);
                #1;
                check("rr_mu_gnt", 32'(mu_gnt), 32'(t % 2 == 0));
                check("rr_hs_gnt", 32'(hs_gnt), 32'(t % 2 == 1));
            end else begin
                mu_req = 1'b0; hs_req = 1'b0;
            end
            tick();
            check("rr_mu_rvalid", 32'(mu_rvalid), 32'(t == 3 || t == 5));
            check("rr_hs_rvalid", 32'(hs_rvalid), 32'(t == 4 || t == 6));
            if (t == 3) check("rr_mu_rdata0", mu_rdata, 32'hA0);
            if (t == 4) check("rr_hs_rdata1", hs_rdata, 32'hC000_0001);
            if (t == 5) check("rr_mu_rdata2", mu_rdata, 32'hA2);
            if (t == 5) check("rr_hs_rdata_hold", hs_rdata, 32'hC000_0001);
            if (t == 6) check("rr_hs_rdata3", hs_rdata, 32'hC000_0003);
        end

        // start is ignored in COMPUTE
        start = 1'b1; tick(); start = 1'b0;
        check("start_in_compute", 32'(phase), 2);

        // ---------------- drops: row 0x400, sel 3; then row 0x3FF returns
        for (int t = 0; t < 7; t++) begin
            mu_req = (t < 3);
            mu_sel = (t == 1) ? 2'd3 : 2'd2;
            mu_addr = (t == 0) ? 14'h0400 : ((t == 1) ? 14'h0005 : 14'h03FF);
            if (t < 3) begin
                #1;
                check("drop_mu_gnt", 32'(mu_gnt), 1);
            end
            tick();
            check("drop_err", 32'(err), 32'(t <= 1));
            check("drop_we", 32'({we_val, we_col, we_row}), 0);
            check("drop_mu_rvalid", 32'(mu_rvalid), 32'(t == 5));
            check("drop_hs_rvalid", 32'(hs_rvalid), 0);
            if (t == 0) check("drop_addr_row_held", 32'(addr_row), 0);
            if (t == 1) check("drop_addr_val_held", 32'(addr_val), 2);
            if (t == 2) check("row_addr_3ff", 32'(addr_row), 32'h3FF);
            if (t == 5) check("row_rdata_3ff", mu_rdata, 32'hD000_03FF);
        end

        // ---------------- mid-run reset after two accepted reads
        mu_req = 1'b1; mu_sel = 2'd0; mu_addr = 14'd0;
        tick();
        mu_addr = 14'd1;
        tick();
        mu_req = 1'b0; reset = 1'b1;
        tick();
        check_all_zero("midrst");
        reset = 1'b0;
        for (int t = 0; t < 4; t++) begin
            tick();
            check("midrst_no_rvalid", 32'({mu_rvalid, hs_rvalid}), 0);
        end

        // ---------------- second run: single column write with ld_last
        start = 1'b1; tick(); start = 1'b0;
        check("run2_load_phase", 32'(phase), 1);
        ld_req = 1'b1; ld_sel = 2'd1; ld_addr = 14'd7; ld_wdata = 32'h77; ld_last = 1'b1;
        tick();
        ld_req = 1'b0; ld_last = 1'b0;
        check("run2_we_col", 32'(we_col), 1);
        check("run2_we_val", 32'(we_val), 0);
        check("run2_addr_col", 32'(addr_col), 7);
        check("run2_din", din, 32'h77);
        check("run2_phase", 32'(phase), 2);
        check("run2_mul_start", 32'(mul_start), 1);

        // ---------------- host read, then mu_done; data returns in FINISH
        hs_req = 1'b1; hs_sel = 2'd0; hs_addr = 14'd2;
        #1;
        check("fin_hs_gnt", 32'(hs_gnt), 1);
        tick();
        hs_req = 1'b0; mu_done = 1'b1;
        tick();
        mu_done = 1'b0;
        check("fin_done", 32'(done), 1);
        check("fin_phase", 32'(phase), 3);
        check("fin_rvalid_early", 32'(hs_rvalid), 0);
        tick();
        check("fin_rvalid_early2", 32'(hs_rvalid), 0);
        tick();
        check("fin_hs_rvalid", 32'(hs_rvalid), 1);
        check("fin_hs_rdata", hs_rdata, 32'hA2);
        check("fin_done_held", 32'(done), 1);
        tick();
        check("fin_rvalid_one_cycle", 32'(hs_rvalid), 0);

        // ---------------- FINISH -> LOAD on start
        start = 1'b1; tick(); start = 1'b0;
        check("restart_phase", 32'(phase), 1);
        check("restart_done", 32'(done), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/csr_port_sched.md
# csr_port_sched

Phase sequencer and port-A scheduler for the three CSR matrix RAMs (value, column-index, row-pointer). It owns the RAM port-A address, write-enable and write-data lines and shares them between three requesters: the matrix loader (writes), the sparse multiplier (reads) and a host readback path (reads). It replaces the ad-hoc `done`-based muxing with an explicit LOAD → COMPUTE → FINISH phase machine, a request/grant handshake and tagged read-data return.

## Interface
- `ADDR_W`, 14, value/column RAM address width; the row RAM uses the low 10 bits.
- `DATA_W`, 32, RAM word width.
- `RD_LAT`, 2, RAM read latency in cycles from address-registered to `dout` valid (≥1).

- `clk` in 1, single clock; all logic is on the rising edge.
- `reset` in 1, synchronous, active-high.
- `start` in 1, begins a load/compute run.
- `phase` out 2, current phase: 0 IDLE, 1 LOAD, 2 COMPUTE, 3 FINISH.
- `mul_start` out 1, one-cycle pulse on entry to COMPUTE.
- `mu_done` in 1, the multiplier has finished.
- `done` out 1, high while `phase` is FINISH.
- `ld_req`, `ld_last` in 1 each; `ld_sel` in 2; `ld_addr` in ADDR_W; `ld_wdata` in DATA_W; `ld_gnt` out 1. Loader write port.
- `mu_req` in 1; `mu_sel` in 2; `mu_addr` in ADDR_W; `mu_gnt` out 1; `mu_rdata` out DATA_W; `mu_rvalid` out 1. Multiplier read port.
- `hs_req` in 1; `hs_sel` in 2; `hs_addr` in ADDR_W; `hs_gnt` out 1; `hs_rdata` out DATA_W; `hs_rvalid` out 1. Host read port.
- `addr_val`, `addr_col` out ADDR_W; `addr_row` out 10; `we_val`, `we_col`, `we_row` out 1; `din` out DATA_W. RAM port A, all registered.
- `dout_val`, `dout_col`, `dout_row` in DATA_W, RAM port-A read data.
- `err` out 1, one-cycle pulse when a request is dropped.

## Operation
- `sel` encoding: 0 value, 1 column, 2 row, 3 reserved.
- Phase FSM:
  - IDLE → LOAD on `start`.
  - LOAD → COMPUTE on the edge where `ld_req & ld_gnt & ld_last` is accepted.
  - COMPUTE → FINISH on `mu_done`.
  - FINISH → LOAD on `start`.
  - `start` is ignored in LOAD and COMPUTE.
- Eligibility by phase:
  - LOAD: loader only.
  - COMPUTE: multiplier and host.
  - IDLE and FINISH: host only.
  - An ineligible requester's `gnt` is 0.
- Grant rules:
  - `gnt` is combinational from the current `req` values and arbiter state.
  - A transfer happens at any edge where `req & gnt` are both high.
  - At most one grant is high per cycle.
  - In COMPUTE, multiplier and host share the port round-robin. If only one requests, it wins. After reset the multiplier has priority; after each grant, priority passes to the other requester.
- Issue:
  - The accepted request's address and write data are registered onto the RAM port.
  - For a row access, `addr_row` gets `addr[9:0]`.
  - A loader request raises exactly the one `we_*` selected by `ld_sel` for one cycle.
  - Every `we_*` is 0 in every other cycle.
  - Address lines hold their last value when nothing is issued.
- Drop rules: a request is accepted but not issued, and `err` pulses on the following cycle, when:
  - `sel` is 3, or
  - `sel` is 2 (row) and `addr[ADDR_W-1:10]` is nonzero.
  - A dropped request produces no `rvalid`.
- Read return:
  - A tag pipeline RD_LAT+1 deep carries {valid, requester, sel}.
  - At the output, the tagged requester's `rdata` takes `dout_val`, `dout_col` or `dout_row` according to the tag's `sel`.
  - That requester's `rvalid` is high for exactly one cycle.
  - `rdata` holds its value between returns.
- Reset, including mid-run:
  - `phase` returns to IDLE.
  - The tag pipeline is flushed, so no `rvalid` follows a reset.
  - All outputs go to 0: `gnt`, `we_*`, `rvalid`, `rdata`, addresses, `din`, `err`, `mul_start`, `done`.

## Timing
- Request accepted at edge k: RAM address/`we` are valid during cycle k…k+1.
- Read data: `rvalid` is high in the cycle following edge k+1+RD_LAT. For RD_LAT=2, the first `rvalid` comes 3 edges after acceptance.
- Throughput: one accepted request per cycle, back-to-back, with no bubbles.
- LOAD→COMPUTE:
  - `phase`=2 and `mul_start`=1 in the cycle after the `ld_last` edge.
  - `mul_start` is low in the next cycle.
- COMPUTE→FINISH: `done`=1 in the cycle after `mu_done` is sampled.
- Reads issued before `mu_done` still return their `rvalid` in FINISH.

## Test plan
- Reset, then `start`, then 4 loader writes (value addr 0..3, data 0xA0..0xA3) with `ld_last` on the 4th → `we_val` pulses 4 consecutive cycles; `phase`=2 and `mul_start` pulses one cycle after the 4th edge.
- In COMPUTE, `mu_req` and `hs_req` both held for 4 cycles → grants alternate mu, hs, mu, hs. With RD_LAT=2, `mu_rvalid` and `hs_rvalid` alternate starting 3 cycles after the first accept, and the data matches the RAM model.
- Row read with `addr` 0x0400, and any read with `sel`=3 → no `we_*`, no `rvalid`, and `err`=1 one cycle after acceptance. A row read at `addr` 0x03FF returns normally.
- `hs_req` in LOAD → `hs_gnt`=0 for the whole LOAD phase. `start` asserted in COMPUTE → `phase` unchanged.
- `reset` asserted one cycle after 2 multiplier reads are accepted → no `rvalid` appears; all outputs are 0 and `phase`=0 on the next cycle.
- `mu_done` pulse → `done`=1 the next cycle. Then `start` → `phase`=1 and `done`=0.
